// File: rtl/multiport_regfile.sv
// Multi-read-port register file with a sequential clear. Reads are registered (1 cycle). Optional write-to-read bypass: MULTIPORT_REGFILE_BYPASS_EN.
// No backpressure: while busy, writes are dropped, reads return rvalid=0, and clr_req is ignored.
module multiport_regfile #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDWIDTH = 5,
  parameter int NREAD    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [ADDWIDTH-1:0]       waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [NREAD-1:0]          re,
  input  logic [NREAD*ADDWIDTH-1:0] raddr,
  output logic [NREAD*WIDTH-1:0]    rdata,
  output logic [NREAD-1:0]          rvalid,
  input  logic                      clr_req,
  output logic                      busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDWIDTH:0]   DEPTH_W = (ADDWIDTH+1)'(DEPTH);
  localparam logic [ADDWIDTH-1:0] LAST    = ADDWIDTH'(DEPTH-1);

  state_t              state, state_nxt;
  logic [ADDWIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == IDLE) begin
      if (clr_req) begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    end else begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == LAST) begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    end
  end

  assign busy  = (state == CLEAR);
  // Out-of-range writes are silently dropped.
  assign wr_en = we && !busy && ({1'b0, waddr} < DEPTH_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDWIDTH-1:0] ra;
    logic                ra_ok;
    logic [WIDTH-1:0]    rd_word;
    logic [WIDTH-1:0]    rd_q;
    logic                rv_q;

    assign ra    = raddr[p*ADDWIDTH +: ADDWIDTH];
    assign ra_ok = ({1'b0, ra} < DEPTH_W);

    always_comb begin
      rd_word = '0;
      if (ra_ok) rd_word = mem[ra];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
      if (wr_en && (waddr == ra)) rd_word = wdata;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else if (re[p] && !busy) begin
        rd_q <= rd_word;
        rv_q <= 1'b1;
      end else begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end
    end

    assign rdata[p*WIDTH +: WIDTH] = rd_q;
    assign rvalid[p]               = rv_q;
  end

endmodule
